// File: rtl/alu_ctrl_pkg.sv
// Shared ALU op-code definitions used by the ALU controller and the
// execution unit, plus the shifter FSM state type.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SRLV = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0100;
    localparam logic [3:0] ALU_LUI  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_ORI  = 4'b1000;
    localparam logic [3:0] ALU_BNE  = 4'b1001;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } shift_state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SRL) || (op == ALU_SRLV);
    endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Logical right shifter: one bit per cycle by default, single-cycle
// barrel shifter when ALU_FAST_SHIFT_EN is defined.
module alu_shift_unit
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [4:0]       amt,
    output logic             busy,
    output logic             fin,
    output logic [WIDTH-1:0] res
);

`ifdef ALU_FAST_SHIFT_EN

    assign busy = 1'b0;
    assign fin  = start;
    assign res  = data >> amt;

`else

    shift_state_t     state;
    shift_state_t     state_nx;
    logic [WIDTH-1:0] shreg;
    logic [4:0]       cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        fin      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nx = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (cnt == 5'd0) begin
                    fin      = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Counter reaching zero marks completion; the shift happens only while nonzero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (start) begin
            shreg <= data;
            cnt   <= amt;
        end else if (state == ST_SHIFT && cnt != 5'd0) begin
            shreg <= shreg >> 1;
            cnt   <= cnt - 5'd1;
        end
    end

    assign res = shreg;

`endif

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU with valid/ready input and registered result/zero/illegal.
// Define ALU_FAST_SHIFT_EN for single-cycle shifts.
module alu_exec_unit
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [4:0]       shamt_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             done_o,
    output logic             illegal_o
);

    logic             accept;
    logic             shift_op;
    logic             sh_start;
    logic             sh_busy;
    logic             sh_fin;
    logic [4:0]       sh_amt;
    logic [WIDTH-1:0] sh_res;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic             alu_zero;

    assign shift_op = is_shift(ALUCtrl_i);
    assign ready_o  = ~sh_busy;
    assign accept   = valid_i && ready_o;
    assign sh_start = accept && shift_op;
    assign sh_amt   = (ALUCtrl_i == ALU_SRL) ? shamt_i : src1_i[4:0];

    alu_shift_unit #(.WIDTH(WIDTH)) u_shift (
        .clk   (clk_i),
        .rst_n (rst_i),
        .start (sh_start),
        .data  (src2_i),
        .amt   (sh_amt),
        .busy  (sh_busy),
        .fin   (sh_fin),
        .res   (sh_res)
    );

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        unique case (ALUCtrl_i)
            ALU_AND:  alu_res = src1_i & src2_i;
            ALU_OR:   alu_res = src1_i | src2_i;
            ALU_ADD:  alu_res = src1_i + src2_i;
            ALU_SUB:  alu_res = src1_i - src2_i;
            ALU_BNE:  alu_res = src1_i - src2_i;
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                                 $signed(src1_i) < $signed(src2_i)};
            ALU_LUI:  alu_res = {src2_i[15:0], {(WIDTH-16){1'b0}}};
            ALU_ORI:  alu_res = src1_i | {{(WIDTH-16){1'b0}}, src2_i[15:0]};
            ALU_SRL,
            ALU_SRLV: alu_res = '0;
            default:  alu_ill = 1'b1;
        endcase
    end

    // bne inverts the sense so branch logic can always test zero_o
    assign alu_zero = (ALUCtrl_i == ALU_BNE) ? (alu_res != '0)
                                             : (alu_res == '0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            result_o  <= '0;
            zero_o    <= 1'b0;
            done_o    <= 1'b0;
            illegal_o <= 1'b0;
        end else if (sh_fin) begin
            result_o  <= sh_res;
            zero_o    <= (sh_res == '0);
            done_o    <= 1'b1;
            illegal_o <= 1'b0;
        end else if (accept && !shift_op) begin
            result_o  <= alu_res;
            zero_o    <= alu_zero;
            done_o    <= 1'b1;
            illegal_o <= alu_ill;
        end else begin
            done_o    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit: vector table for
// single-cycle ops plus hand sequences for shifts and reset abort.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        ready;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  sh = '0;
    logic [31:0] res;
    logic        zero;
    logic        done;
    logic        ill;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .valid_i   (valid),
        .ready_o   (ready),
        .ALUCtrl_i (op),
        .src1_i    (a),
        .src2_i    (b),
        .shamt_i   (sh),
        .result_o  (res),
        .zero_o    (zero),
        .done_o    (done),
        .illegal_o (ill)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
        logic        il;
    } vec_t;

    vec_t vt[13];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one shift and wait for done; expected latency in edges after accept
    task automatic run_shift(input string name, input logic [3:0] o,
                             input logic [31:0] s1, input logic [31:0] s2,
                             input logic [4:0] s, input int k,
                             input logic [31:0] exp, input bit pulse);
        int n;
        int rdy_hi;
        int exp_lat;
`ifdef ALU_FAST_SHIFT_EN
        exp_lat = 0;
`else
        exp_lat = k + 1;
`endif
        op = o; a = s1; b = s2; sh = s; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        n = 0;
        rdy_hi = 0;
        while (!done && n < 40) begin
            if (ready) rdy_hi++;
            if (pulse && n == 5) begin
                valid = 1'b1; op = 4'b0010; a = 32'd1; b = 32'd1;
            end
            if (pulse && n == 10) valid = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        valid = 1'b0;
        check({name, " latency"}, n, exp_lat);
        check({name, " ready_low"}, rdy_hi, 0);
        check({name, " result"}, res, exp);
        check({name, " zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
        check({name, " illegal"}, {31'd0, ill}, 32'd0);
        @(posedge clk); #1;
        check({name, " single_done"}, {31'd0, done}, 32'd0);
        check({name, " ready_after"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        vt[0]  = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0};
        vt[1]  = '{4'b0110, 32'd5,        32'd5,        32'h00000000, 1'b1, 1'b0};
        vt[2]  = '{4'b0111, 32'hFFFFFFFF, 32'd1,        32'h00000001, 1'b0, 1'b0};
        vt[3]  = '{4'b0111, 32'd1,        32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0};
        vt[4]  = '{4'b1001, 32'd3,        32'd4,        32'hFFFFFFFF, 1'b1, 1'b0};
        vt[5]  = '{4'b1001, 32'd4,        32'd4,        32'h00000000, 1'b0, 1'b0};
        vt[6]  = '{4'b0101, 32'h0000DEAD, 32'h00001234, 32'h12340000, 1'b0, 1'b0};
        vt[7]  = '{4'b1000, 32'hF0000000, 32'hFFFF00FF, 32'hF00000FF, 1'b0, 1'b0};
        vt[8]  = '{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
        vt[9]  = '{4'b0001, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
        vt[10] = '{4'b1111, 32'd5,        32'd6,        32'h00000000, 1'b1, 1'b1};
        vt[11] = '{4'b0010, 32'd1,        32'd2,        32'h00000003, 1'b0, 1'b0};
        vt[12] = '{4'b1010, 32'hFFFFFFFF, 32'h1,        32'h00000000, 1'b1, 1'b1};

        // Reset asserted mid-cycle must clear outputs without a clock edge
        #3 rst = 1'b0;
        #1;
        check("rst result", res, 32'd0);
        check("rst zero", {31'd0, zero}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst illegal", {31'd0, ill}, 32'd0);
        check("rst ready", {31'd0, ready}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        // Back-to-back single-cycle ops, valid held high
        for (int i = 0; i < 13; i++) begin
            op = vt[i].op; a = vt[i].a; b = vt[i].b; sh = 5'd0;
            valid = 1'b1;
            @(posedge clk); #1;
            check($sformatf("v%0d result", i), res, vt[i].r);
            check($sformatf("v%0d zero", i), {31'd0, zero}, {31'd0, vt[i].z});
            check($sformatf("v%0d illegal", i), {31'd0, ill}, {31'd0, vt[i].il});
            check($sformatf("v%0d done", i), {31'd0, done}, 32'd1);
        end
        valid = 1'b0;
        @(posedge clk); #1;
        check("idle done", {31'd0, done}, 32'd0);
        check("held result", res, 32'd0);
        check("held illegal", {31'd0, ill}, 32'd1);

        run_shift("srl31", 4'b0100, 32'h0, 32'h80000000, 5'd31, 31,
                  32'h00000001, 1'b1);
        run_shift("srlv_k0", 4'b0011, 32'h00000020, 32'hA5A5A5A5, 5'd7, 0,
                  32'hA5A5A5A5, 1'b0);
        run_shift("srlv4", 4'b0011, 32'h00000004, 32'h000000F0, 5'd0, 4,
                  32'h0000000F, 1'b0);
        run_shift("srl0z", 4'b0100, 32'hFFFFFFFF, 32'h0, 5'd0, 0,
                  32'h00000000, 1'b0);
        run_shift("srl3", 4'b0100, 32'h0, 32'hF000000F, 5'd3, 3,
                  32'h1E000001, 1'b0);

        // Reset in the middle of a long shift aborts with no done
        op = 4'b0100; b = 32'h80000000; sh = 5'd31; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort result", res, 32'd0);
        check("abort ready", {31'd0, ready}, 32'd1);
        begin
            int seen = 0;
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                if (done) seen++;
            end
            @(negedge clk) rst = 1'b1;
            for (int i = 0; i < 30; i++) begin
                @(posedge clk); #1;
                if (done) seen++;
            end
            check("abort no_done", seen, 0);
        end
        op = 4'b0010; a = 32'd2; b = 32'd3; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        check("post_abort result", res, 32'd5);
        check("post_abort done", {31'd0, done}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
